// File: rtl/phy_rx_serial_to_parallel_pkg.sv
// Shared definitions for the phy_rx front end: comma symbol, counter widths
// and the alignment state encoding.
package phy_rx_serial_to_parallel_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned BIT_CNT_W   = 3;
    localparam int unsigned BC_CNT_W    = 4;

    localparam logic [BYTE_W-1:0] COMMA_DEFAULT       = 8'hBC;
    localparam int unsigned       COMMA_COUNT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_UNALIGNED = 2'd0,
        ST_SYNC      = 2'd1,
        ST_ACTIVE    = 2'd2
    } rx_state_e;

endpackage

// File: rtl/phy_rx_comma_detect.sv
// Serial shift register plus comparator flagging when the byte completing on
// this edge equals the comma symbol.
module phy_rx_comma_detect
    import phy_rx_serial_to_parallel_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA = COMMA_DEFAULT
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [BYTE_W-1:0] cand_c,
    output logic              comma_c
);

    logic [BYTE_W-1:0] sr_q;
    logic [BYTE_W-1:0] sr_d;

    always_comb begin
        sr_d    = {sr_q[BYTE_W-2:0], data_in};
        cand_c  = sr_d;
        comma_c = (sr_d == COMMA);
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/phy_rx_serial_to_parallel.sv
// Serial-to-parallel front stage: comma-based byte alignment, then one
// registered byte plus strobe every 8 bit clocks, with idle commas marked invalid.
module phy_rx_serial_to_parallel
    import phy_rx_serial_to_parallel_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA       = COMMA_DEFAULT,
    parameter int unsigned       COMMA_COUNT = COMMA_COUNT_DEFAULT
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              byte_strobe,
    output logic              active
);

    localparam logic [BC_CNT_W-1:0] COMMA_COUNT_V = BC_CNT_W'(COMMA_COUNT);

    rx_state_e              state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BC_CNT_W-1:0]    bc_cnt_q, bc_cnt_d;
    logic [BC_CNT_W-1:0]    bc_inc;
    logic [BYTE_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   strobe_q, strobe_d;
    logic                   active_q, active_d;
    logic                   boundary;

    logic [BYTE_W-1:0]      cand;
    logic                   is_comma;

    phy_rx_comma_detect #(
        .COMMA (COMMA)
    ) u_comma_detect (
        .clk_32f (clk_32f),
        .reset   (reset),
        .data_in (data_in),
        .cand_c  (cand),
        .comma_c (is_comma)
    );

    // Alignment FSM and output capture.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;
        active_d  = active_q;
        bc_inc    = bc_cnt_q + BC_CNT_W'(1);
        boundary  = (bit_cnt_q == '1);

        case (state_q)
            ST_UNALIGNED: begin
                if (is_comma) begin
                    bit_cnt_d = '0;
                    bc_cnt_d  = BC_CNT_W'(1);
                    if (COMMA_COUNT == 1) begin
                        state_d  = ST_ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d  = ST_SYNC;
                    end
                end
            end
            ST_SYNC: begin
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_d = bc_inc;
                        if (bc_inc == COMMA_COUNT_V) begin
                            state_d  = ST_ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        state_d  = ST_UNALIGNED;
                        bc_cnt_d = '0;
                    end
                end
            end
            ST_ACTIVE: begin
                if (boundary) begin
                    data_d   = cand;
                    valid_d  = !is_comma;
                    strobe_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_UNALIGNED;
            end
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q   <= ST_UNALIGNED;
            bit_cnt_q <= '0;
            bc_cnt_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
            active_q  <= active_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_phy_rx_serial_to_parallel.sv
// Randomised and directed bench for phy_rx_serial_to_parallel, checked every
// cycle against a bit-index based alignment model.
module tb_phy_rx_serial_to_parallel;

    localparam logic [7:0] C_COMMA = 8'hBC;
    localparam int         C_COUNT = 4;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int checks;
    int failures;

    phy_rx_serial_to_parallel dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    initial begin
        clk_32f = 1'b0;
        forever #5 clk_32f = ~clk_32f;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: bit index since reset, index of the comma that set the byte grid,
    // count of consecutive on-grid commas.
    int         m_idx, m_anchor, m_commas;
    bit         m_locked, m_active;
    logic [7:0] m_hist;
    logic [7:0] exp_data;
    bit         exp_valid, exp_strobe;

    always @(posedge clk_32f or posedge reset) begin
        logic [7:0] cand;
        if (reset) begin
            m_idx = 0; m_anchor = 0; m_commas = 0;
            m_locked = 0; m_active = 0; m_hist = 8'h00;
            exp_data = 8'h00; exp_valid = 0; exp_strobe = 0;
        end else begin
            cand = {m_hist[6:0], data_in};
            m_hist = cand;
            exp_strobe = 0;
            if (!m_locked) begin
                if (cand == C_COMMA) begin
                    m_locked = 1; m_anchor = m_idx; m_commas = 1;
                    if (C_COUNT == 1) m_active = 1;
                end
            end else if (((m_idx - m_anchor) % 8) == 0) begin
                if (m_active) begin
                    exp_strobe = 1; exp_data = cand; exp_valid = (cand != C_COMMA);
                end else if (cand == C_COMMA) begin
                    m_commas++;
                    if (m_commas == C_COUNT) m_active = 1;
                end else begin
                    m_locked = 0;
                end
            end
            m_idx++;
        end
    end

    // Per-cycle compare plus capture of strobed bytes for directed checks.
    int         cyc;
    int         act_rise_cyc;
    bit         prev_active;
    logic [7:0] cap_data[$];
    bit         cap_valid[$];
    int         cap_cyc[$];

    always @(posedge clk_32f) cyc++;

    always @(negedge clk_32f) begin
        check("model_strobe", 32'(byte_strobe), 32'(exp_strobe));
        check("model_active", 32'(active), 32'(m_active));
        check("model_data", 32'(data_out), 32'(exp_data));
        check("model_valid", 32'(valid_out), 32'(exp_valid));
        if (byte_strobe) begin
            cap_data.push_back(data_out);
            cap_valid.push_back(valid_out);
            cap_cyc.push_back(cyc);
        end
        if (active && !prev_active) act_rise_cyc = cyc;
        prev_active = active;
    end

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        @(negedge clk_32f);
        reset = 1'b1;
        data_in = 1'b0;
        @(negedge clk_32f);
        reset = 1'b0;
    endtask

    task automatic clear_cap();
        cap_data.delete();
        cap_valid.delete();
        cap_cyc.delete();
    endtask

    task automatic flush();
        @(negedge clk_32f);
        #1;
    endtask

    initial begin
        logic [7:0] exp_b[4];
        logic [7:0] bits3;
        checks = 0;
        failures = 0;
        cyc = 0;
        prev_active = 0;
        act_rise_cyc = -1;
        reset = 1'b1;
        data_in = 1'b0;
        #12;
        check("reset_data", 32'(data_out), 32'h00);
        check("reset_valid", 32'(valid_out), 32'h0);
        check("reset_strobe", 32'(byte_strobe), 32'h0);
        check("reset_active", 32'(active), 32'h0);
        @(negedge clk_32f);
        reset = 1'b0;

        // Lock on four commas; active exactly on the 32nd bit.
        clear_cap();
        for (int i = 0; i < 3; i++) send_byte(C_COMMA);
        for (int i = 7; i >= 1; i--) send_bit(C_COMMA[i]);
        check("lock_active_bit31", 32'(active), 32'h0);
        send_bit(C_COMMA[0]);
        check("lock_active_bit32", 32'(active), 32'h1);
        flush();
        check("lock_no_strobe", 32'(cap_data.size()), 32'd0);

        // Payload after lock.
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(C_COMMA);
        clear_cap();
        exp_b = '{8'hFF, 8'hBB, 8'hEA, 8'hCC};
        for (int i = 0; i < 4; i++) send_byte(exp_b[i]);
        flush();
        check("payload_count", 32'(cap_data.size()), 32'd4);
        if (cap_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("payload_data", 32'(cap_data[i]), 32'(exp_b[i]));
                check("payload_valid", 32'(cap_valid[i]), 32'h1);
            end
            check("first_strobe_gap", 32'(cap_cyc[0] - act_rise_cyc), 32'd8);
            for (int i = 1; i < 4; i++)
                check("strobe_spacing", 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd8);
        end

        // Bit-offset stream.
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_byte(C_COMMA);
        check("offset_active", 32'(active), 32'h1);
        clear_cap();
        send_byte(8'h15);
        flush();
        check("offset_count", 32'(cap_data.size()), 32'd1);
        if (cap_data.size() == 1) begin
            check("offset_data", 32'(cap_data[0]), 32'h15);
            check("offset_valid", 32'(cap_valid[0]), 32'h1);
        end

        // Broken comma run restarts the count.
        do_reset();
        send_byte(C_COMMA); send_byte(C_COMMA); send_byte(8'h55);
        for (int i = 0; i < 3; i++) send_byte(C_COMMA);
        check("broken_not_active", 32'(active), 32'h0);
        send_byte(C_COMMA);
        check("broken_active", 32'(active), 32'h1);

        // Idle commas marked invalid.
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(C_COMMA);
        clear_cap();
        send_byte(8'h16); send_byte(C_COMMA); send_byte(8'h16);
        flush();
        check("idle_count", 32'(cap_data.size()), 32'd3);
        if (cap_data.size() == 3) begin
            check("idle_d0", 32'(cap_data[0]), 32'h16);
            check("idle_d1", 32'(cap_data[1]), 32'hBC);
            check("idle_d2", 32'(cap_data[2]), 32'h16);
            check("idle_v0", 32'(cap_valid[0]), 32'h1);
            check("idle_v1", 32'(cap_valid[1]), 32'h0);
            check("idle_v2", 32'(cap_valid[2]), 32'h1);
        end

        // Asynchronous reset mid-byte while active.
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(C_COMMA);
        send_byte(8'h16);
        check("pre_rst_data", 32'(data_out), 32'h16);
        bits3 = 8'hA5;
        for (int i = 7; i >= 5; i--) send_bit(bits3[i]);
        #1 reset = 1'b1;
        #1;
        check("async_rst_data", 32'(data_out), 32'h00);
        check("async_rst_valid", 32'(valid_out), 32'h0);
        check("async_rst_strobe", 32'(byte_strobe), 32'h0);
        check("async_rst_active", 32'(active), 32'h0);
        @(negedge clk_32f);
        reset = 1'b0;
        data_in = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(C_COMMA);
        check("reacq_not_active", 32'(active), 32'h0);
        send_byte(C_COMMA);
        check("reacq_active", 32'(active), 32'h1);

        // Randomised traffic with slips and occasional resets.
        do_reset();
        for (int n = 0; n < 500; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                do_reset();
            end else if (r < 3) begin
                int nb;
                nb = int'($urandom_range(1, 7));
                for (int k = 0; k < nb; k++) send_bit(1'($urandom_range(0, 1)));
            end else if (r < 6) begin
                for (int k = 0; k < 4; k++) send_byte(C_COMMA);
            end else if (r < 9) begin
                send_byte(C_COMMA);
            end else begin
                send_byte(8'($urandom_range(0, 255)));
            end
        end
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/phy_rx_serial_to_parallel.md
Name: phy_rx_serial_to_parallel

Overview:
- Front stage of the phy_rx path. Converts the 1-bit serial line into 8-bit bytes with a valid flag.
- Feeds the byte-wide demux stage (data_000/valid_000 side) through a byte strobe, so the downstream stage runs on this block's clock with a qualifier.
- Acquires byte alignment by locking onto a comma symbol, 0xBC.
- Once active, idle comma bytes are marked invalid.

Parameters:
- COMMA, 8'hBC, alignment/idle symbol.
- COMMA_COUNT, 4, consecutive aligned commas required to go ACTIVE (legal range 1..15).

Ports:
- clk_32f  input  1  bit clock; one serial bit per rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  1  serial bit, MSB of each byte first.
- data_out  output  8  last completed byte.
- valid_out  output  1  data_out is payload, not comma.
- byte_strobe  output  1  one-cycle pulse when data_out/valid_out update.
- active  output  1  alignment acquired.

Behaviour:
- Clock and reset: one clock, clk_32f. Reset is asynchronous and active-high.
- Reset values: all outputs 0, shift register 0, bit_cnt 0, bc_cnt 0, state UNALIGNED.
  - Reset may assert at any time, including mid-byte. Its effect is immediate; no partial byte is emitted afterwards.
- Shift register: every cycle `sr <= {sr[6:0], data_in}`.
  - Candidate byte `cand = {sr[6:0], data_in}`, i.e. the byte completing on this edge.
- UNALIGNED:
  - Compare cand to COMMA on every cycle (bit-slip search).
  - On a match: bit_cnt <= 0 (byte boundary), bc_cnt <= 1, go to SYNC. If COMMA_COUNT == 1, go straight to ACTIVE instead.
  - No outputs are updated in this state.
- SYNC:
  - bit_cnt increments modulo 8. The boundary is the cycle where bit_cnt == 7.
  - At a boundary with cand == COMMA: bc_cnt++. When the incremented value equals COMMA_COUNT, go to ACTIVE and set active <= 1.
  - At a boundary with cand != COMMA: go to UNALIGNED, bc_cnt <= 0. Searching resumes on the next cycle.
  - No data is emitted in this state.
- ACTIVE:
  - bit_cnt keeps counting. At each boundary: data_out <= cand, valid_out <= (cand != COMMA), byte_strobe <= 1. On all other cycles byte_strobe <= 0.
  - data_out and valid_out hold between strobes.
  - Comma bytes in ACTIVE are emitted with data_out = COMMA and valid_out = 0.
  - ACTIVE is left only via reset; there is no loss-of-lock detection in this revision.
- Latency: the last bit of a byte is sampled on edge N, and data_out/valid_out/byte_strobe are visible after edge N (registered, one cycle).
  - Strobes are exactly 8 cycles apart.
- Transition timing: active rises on the boundary edge of the COMMA_COUNT-th comma. The first strobe follows 8 cycles later.
- bit_cnt is 3 bits and wraps 7 -> 0. bc_cnt is 4 bits and saturates at COMMA_COUNT.
- Only the lower 3 bits of bit_cnt are meaningful in UNALIGNED.

Decomposition:
- Shared phy package holds:
  - COMMA default (8'hBC);
  - state encoding typedef (UNALIGNED, SYNC, ACTIVE);
  - bit counter and comma counter widths.
- One natural sub-module, phy_rx_comma_detect: shift register plus the cand == COMMA comparator. The parent keeps the FSM and output registers.

Test Plan:
- Reset, then BC x4 MSB-first -> active = 1 after the 32nd bit's edge. No byte_strobe before that.
- Aligned lock, then bytes FF, BB, EA, CC -> four strobes 8 cycles apart with data_out FF/BB/EA/CC and valid_out = 1 each; first strobe 8 cycles after active.
- Three garbage bits (1,0,1), then BC x4, then 15 -> alignment found despite offset; strobe with data_out = 15, valid_out = 1.
- BC, BC, 55, BC x4 -> after 55, returns to UNALIGNED with no active; active only after the last four commas.
- ACTIVE, then stream 16, BC, 16 -> data_out 16/BC/16 with valid_out 1/0/1; three strobes.
- Reset asserted 3 bits into a byte while ACTIVE -> outputs 0 immediately (asynchronous); after release, re-acquisition needs 4 fresh commas.
